lshifdown_bank: RTL and testbench

- Parametrised, multi-channel successor to the single-bit down-level-shifter cell.
- Carries WIDTH signals from a higher-voltage source domain into the core 3.3 V clock domain.
- Per channel: synchroniser, optional glitch filter, registered output.
- A power-sequencing FSM clamps all outputs to a known value while the source domain is unpowered, isolated or settling.
- Instantiated at power-domain boundaries in 9T/12T gp3v3 designs, in place of banks of discrete shifter cells.

---
 rtl/gf180mcu_osu_sc_lshif_pkg.sv | 20 ++
 rtl/lshifdown_bank_if.sv | 28 ++
 rtl/lshif_chan_sync.sv | 59 +++++
 rtl/lshifdown_bank.sv | 108 ++++++++++
 tb/tb_lshifdown_bank.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gf180mcu_osu_sc_lshif_pkg.sv
// Shared definitions for the lshifdown_bank level-shifter bank: the power-sequencing
// state encoding and the counter-width helpers.
package gf180mcu_osu_sc_lshif_pkg;

  // Encoding 2'd3 is unused; the FSM treats it as ISO.
  typedef enum logic [1:0] {
    ISO    = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } lshif_state_e;

  function automatic int settle_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int filt_cnt_w(input int f);
    return (f <= 0) ? 1 : $clog2(f + 1);
  endfunction

endpackage

// File: rtl/lshifdown_bank_if.sv
// Signal bundle between the source-domain side and the lshifdown_bank core.
interface lshifdown_bank_if #(
  parameter int WIDTH = 8
);
  import gf180mcu_osu_sc_lshif_pkg::*;

  logic [WIDTH-1:0] A;
  logic             PWR_OK;
  logic             ISO_REQ;
  logic [WIDTH-1:0] Y;
  logic             READY;
  logic             ISO_ACK;
  logic             CHG;
  lshif_state_e     dbg_state;

  // No valid/ready transfer here: Y is a level, meaningful only while READY is high.
  // READY/ISO_ACK are state decodes, and CHG flags the cycle in which Y holds a new value.
  modport master (
    output A, PWR_OK, ISO_REQ,
    input  Y, READY, ISO_ACK, CHG, dbg_state
  );

  modport slave (
    input  A, PWR_OK, ISO_REQ,
    output Y, READY, ISO_ACK, CHG, dbg_state
  );

endinterface

// File: rtl/lshif_chan_sync.sv
// Single-channel synchroniser plus optional glitch filter; produces the next output
// value for the channel given its current registered output.
module lshif_chan_sync
  import gf180mcu_osu_sc_lshif_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic load,
  input  logic en,
  input  logic y,
  output logic y_nxt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign y_nxt = (load | en) ? s : y;
    end else begin : g_filt
      localparam int            CW       = filt_cnt_w(FILTER_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES);

      logic [CW-1:0] cnt_q, cnt_d;

      // The counter only runs while the synchronised input disagrees with Y,
      // so any return to agreement discards the partial count.
      always_comb begin
        cnt_d = '0;
        y_nxt = y;
        if (load) begin
          y_nxt = s;
        end else if (en && (s != y)) begin
          if (cnt_q == CNT_LAST) y_nxt = s;
          else                   cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/lshifdown_bank.sv
// Multi-channel down-level-shifter bank: per-channel synchronise/filter, and a
// power-sequencing FSM that clamps Y while the source domain is not usable.
module lshifdown_bank
  import gf180mcu_osu_sc_lshif_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               SYNC_STAGES   = 2,
  parameter int               SETTLE_CYCLES = 16,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] CLAMP_VAL     = {WIDTH{1'b0}}
) (
  input logic              CLK,
  input logic              RN,
  lshifdown_bank_if.slave  bus
);

  localparam int             SCW         = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  lshif_state_e     state_q, state_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic [WIDTH-1:0] y_q, y_d, y_nxt;
  logic             ready_q, ready_d;
  logic             iso_ack_q, iso_ack_d;
  logic             chg_q, chg_d;
  logic             pok_s, drop, load_w, en_w;

  lshif_chan_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(0)
  ) u_pok_sync (
    .clk  (CLK),
    .rst_n(RN),
    .d    (bus.PWR_OK),
    .load (1'b1),
    .en   (1'b0),
    .y    (1'b0),
    .y_nxt(pok_s)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    lshif_chan_sync #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_chan (
      .clk  (CLK),
      .rst_n(RN),
      .d    (bus.A[i]),
      .load (load_w),
      .en   (en_w),
      .y    (y_q[i]),
      .y_nxt(y_nxt[i])
    );
  end

  assign drop = !pok_s || bus.ISO_REQ;

  // Dropping out of SETTLE takes priority over settle completion.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    case (state_q)
      ISO:     if (!drop) state_d = SETTLE;
      SETTLE: begin
        if (drop)                         state_d = ISO;
        else if (settle_q == SETTLE_LAST) state_d = ACTIVE;
        else                              settle_d = settle_q + SCW'(1);
      end
      ACTIVE:  if (drop) state_d = ISO;
      default: state_d = ISO;
    endcase
  end

  // Outputs are decoded from the next state so clamping lands on the transition edge.
  always_comb begin
    load_w    = (state_q != ACTIVE) && (state_d == ACTIVE);
    en_w      = (state_q == ACTIVE) && (state_d == ACTIVE);
    y_d       = (state_d == ACTIVE) ? y_nxt : CLAMP_VAL;
    ready_d   = (state_d == ACTIVE);
    iso_ack_d = (state_d == ISO);
    chg_d     = (y_d != y_q);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ISO;
      settle_q  <= '0;
      y_q       <= CLAMP_VAL;
      ready_q   <= 1'b0;
      iso_ack_q <= 1'b1;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      y_q       <= y_d;
      ready_q   <= ready_d;
      iso_ack_q <= iso_ack_d;
      chg_q     <= chg_d;
    end
  end

  assign bus.Y         = y_q;
  assign bus.READY     = ready_q;
  assign bus.ISO_ACK   = iso_ack_q;
  assign bus.CHG       = chg_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lshifdown_bank.sv
// Directed bench for lshifdown_bank: one instance with the filter bypassed, one with
// a 4-cycle filter, both clamping to 8'hA5 with a 16-cycle settle.
module tb_lshifdown_bank;
  import gf180mcu_osu_sc_lshif_pkg::*;

  localparam logic [7:0] CLAMP = 8'hA5;

  logic       clk;
  logic       rn;
  logic [7:0] a;
  logic       pwr_ok;
  logic       iso_req;

  int n_vec = 0;
  int n_err = 0;

  lshifdown_bank_if #(.WIDTH(8)) bus0 ();
  lshifdown_bank_if #(.WIDTH(8)) bus4 ();

  assign bus0.A       = a;
  assign bus0.PWR_OK  = pwr_ok;
  assign bus0.ISO_REQ = iso_req;
  assign bus4.A       = a;
  assign bus4.PWR_OK  = pwr_ok;
  assign bus4.ISO_REQ = iso_req;

  lshifdown_bank #(
    .WIDTH(8), .SYNC_STAGES(2), .SETTLE_CYCLES(16), .FILTER_CYCLES(0), .CLAMP_VAL(CLAMP)
  ) dut0 (
    .CLK(clk), .RN(rn), .bus(bus0)
  );

  lshifdown_bank #(
    .WIDTH(8), .SYNC_STAGES(2), .SETTLE_CYCLES(16), .FILTER_CYCLES(4), .CLAMP_VAL(CLAMP)
  ) dut4 (
    .CLK(clk), .RN(rn), .bus(bus4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] exp_y;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_clamped(input string name);
    check({name, " y0"}, 32'(bus0.Y), 32'(CLAMP));
    check({name, " y4"}, 32'(bus4.Y), 32'(CLAMP));
    check({name, " ready"}, 32'(bus0.READY), 32'd0);
  endtask

  initial begin
    logic [7:0] prev_y;

    vecs[0] = '{a: 8'h00, exp_y: 8'h00, exp_chg: 1'b1};
    vecs[1] = '{a: 8'h3C, exp_y: 8'h3C, exp_chg: 1'b1};
    vecs[2] = '{a: 8'hC3, exp_y: 8'hC3, exp_chg: 1'b1};
    vecs[3] = '{a: 8'hC3, exp_y: 8'hC3, exp_chg: 1'b0};
    vecs[4] = '{a: 8'hFF, exp_y: 8'hFF, exp_chg: 1'b1};
    vecs[5] = '{a: 8'h00, exp_y: 8'h00, exp_chg: 1'b1};

    rn = 1'b0; a = 8'h5A; pwr_ok = 1'b0; iso_req = 1'b0;
    #12;
    check("rst y", 32'(bus0.Y), 32'(CLAMP));
    check("rst ready", 32'(bus0.READY), 32'd0);
    check("rst iso_ack", 32'(bus0.ISO_ACK), 32'd1);
    check("rst chg", 32'(bus0.CHG), 32'd0);
    check("rst state", 32'(bus0.dbg_state), 32'(ISO));

    @(posedge clk); #1; rn = 1'b1;
    tick(5);
    check("iso no pok", 32'(bus0.dbg_state), 32'(ISO));
    check_clamped("iso no pok");

    // power up: 2 sync edges, 1 ISO->SETTLE edge, 16 settle edges
    pwr_ok = 1'b1;
    tick(3);
    check("pwrup settle", 32'(bus0.dbg_state), 32'(SETTLE));
    tick(15);
    check_clamped("pwrup edge18");
    tick(1);
    check("pwrup ready", 32'(bus0.READY), 32'd1);
    check("pwrup iso_ack", 32'(bus0.ISO_ACK), 32'd0);
    check("pwrup y0 load", 32'(bus0.Y), 32'h5A);
    check("pwrup y4 load", 32'(bus4.Y), 32'h5A);
    check("pwrup chg", 32'(bus0.CHG), 32'd1);
    tick(1);
    check("pwrup chg clr", 32'(bus0.CHG), 32'd0);

    // unfiltered vector table: Y follows A after 3 edges
    prev_y = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      a = vecs[i].a;
      tick(2);
      check("tbl hold", 32'(bus0.Y), 32'(prev_y));
      tick(1);
      check("tbl y", 32'(bus0.Y), 32'(vecs[i].exp_y));
      check("tbl chg", 32'(bus0.CHG), 32'(vecs[i].exp_chg));
      tick(1);
      check("tbl chg clr", 32'(bus0.CHG), 32'd0);
      prev_y = vecs[i].exp_y;
    end
    tick(10);
    check("filt settled", 32'(bus4.Y), 32'h00);

    // 3-cycle pulse never reaches the filtered output
    a = 8'h01;
    tick(3);
    a = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("short pulse y", 32'(bus4.Y), 32'h00);
      check("short pulse chg", 32'(bus4.CHG), 32'd0);
    end

    // 6-cycle pulse: toggles 7 edges after onset, back 7 edges after the fall
    a = 8'h01;
    tick(6);
    check("long pulse pre", 32'(bus4.Y), 32'h00);
    a = 8'h00;
    tick(1);
    check("long pulse rise", 32'(bus4.Y), 32'h01);
    check("long pulse chg", 32'(bus4.CHG), 32'd1);
    tick(1);
    check("long pulse chg clr", 32'(bus4.CHG), 32'd0);
    tick(4);
    check("long pulse hold", 32'(bus4.Y), 32'h01);
    tick(1);
    check("long pulse fall", 32'(bus4.Y), 32'h00);
    check("long pulse chg2", 32'(bus4.CHG), 32'd1);

    // ISO_REQ for one cycle while ACTIVE
    a = 8'hFF;
    tick(10);
    check("pre iso y0", 32'(bus0.Y), 32'hFF);
    check("pre iso y4", 32'(bus4.Y), 32'hFF);
    iso_req = 1'b1;
    tick(1);
    iso_req = 1'b0;
    check_clamped("iso_req");
    check("iso_req ack", 32'(bus0.ISO_ACK), 32'd1);
    check("iso_req chg", 32'(bus0.CHG), 32'd1);
    tick(16);
    check_clamped("reentry edge17");
    tick(1);
    check("reentry ready", 32'(bus0.READY), 32'd1);
    check("reentry y0", 32'(bus0.Y), 32'hFF);
    check("reentry y4", 32'(bus4.Y), 32'hFF);

    // PWR_OK loss from ACTIVE, then a drop at settle count 10
    pwr_ok = 1'b0;
    tick(2);
    check("pok loss still active", 32'(bus0.READY), 32'd1);
    tick(1);
    check_clamped("pok loss");
    tick(3);
    pwr_ok = 1'b1;
    tick(11);
    pwr_ok = 1'b0;
    tick(2);
    check("mid settle state", 32'(bus0.dbg_state), 32'(SETTLE));
    tick(1);
    check("mid settle abort", 32'(bus0.dbg_state), 32'(ISO));
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_clamped("aborted settle");
    end
    pwr_ok = 1'b1;
    tick(18);
    check_clamped("restart edge18");
    tick(1);
    check("restart ready", 32'(bus0.READY), 32'd1);
    check("restart y4", 32'(bus4.Y), 32'hFF);

    // asynchronous reset mid-ACTIVE
    @(posedge clk); #3;
    rn = 1'b0;
    #1;
    check_clamped("async rst");
    check("async rst ack", 32'(bus0.ISO_ACK), 32'd1);
    check("async rst chg", 32'(bus0.CHG), 32'd0);
    tick(2);
    rn = 1'b1;
    tick(2);
    check("post rst iso", 32'(bus0.dbg_state), 32'(ISO));
    check_clamped("post rst");
    tick(1);
    check("post rst settle", 32'(bus0.dbg_state), 32'(SETTLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
